// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the RAM arbiter: request/response bus structs and the read tag
// that travels alongside each access until the RAM answers.
package ram_arbiter_pkg;

  localparam int unsigned NumReq     = 2;
  localparam int unsigned RamLatency = 3;
  localparam int unsigned RamDepth   = 256;
  localparam int unsigned RamWidth   = 8;
  localparam int unsigned AddrW      = $clog2(RamDepth);
  localparam int unsigned ReqIdW     = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef struct packed {
    logic                en;
    logic                wen;
    logic [AddrW-1:0]    addr;
    logic [RamWidth-1:0] data;
  } ram_in_t;

  typedef struct packed {
    logic                dv;
    logic [RamWidth-1:0] data;
    logic [AddrW-1:0]    addr;
  } ram_out_t;

  typedef struct packed {
    logic              rd_valid;
    logic [ReqIdW-1:0] req_id;
    logic [AddrW-1:0]  addr;
  } arb_tag_t;

  // Stage 0 shadows the registered RAM request; the top stage lines up with dv.
  typedef arb_tag_t [RamLatency:0] arb_tag_pipe_t;

  function automatic logic [ReqIdW-1:0] next_id(input logic [ReqIdW-1:0] id);
    return (id == ReqIdW'(NumReq - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester, response and RAM-side signals of the arbiter. RAM_ARB_LOCK_EN adds the per-requester
// lock input used for atomic bursts.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic [NumReq-1:0]                req_vld;
  logic [NumReq-1:0]                req_wen;
  logic [NumReq-1:0][AddrW-1:0]     req_addr;
  logic [NumReq-1:0][RamWidth-1:0]  req_data;
  logic [NumReq-1:0]                req_rdy;
`ifdef RAM_ARB_LOCK_EN
  logic [NumReq-1:0]                req_lock;
`endif
  logic [NumReq-1:0]                rsp_vld;
  logic [RamWidth-1:0]              rsp_data;
  logic [AddrW-1:0]                 rsp_addr;
  logic                             busy;
  logic                             err;
  ram_in_t                          ram_req;
  ram_out_t                         ram_rsp;

  modport master (
`ifdef RAM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_vld, req_wen, req_addr, req_data,
    input  req_rdy, rsp_vld, rsp_data, rsp_addr, busy, err
  );

  modport slave (
`ifdef RAM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_vld, req_wen, req_addr, req_data, ram_rsp,
    output req_rdy, rsp_vld, rsp_data, rsp_addr, busy, err, ram_req
  );

  modport mem (
    input  ram_req,
    output ram_rsp
  );

endinterface

// File: rtl/ram_arbiter_rr_grant.sv
// Combinational one-hot round-robin picker. The lock override (driven only when RAM_ARB_LOCK_EN is
// defined in the top) pins the grant to lock_id while that requester keeps its valid high.
module ram_arbiter_rr_grant #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdW    = 1
) (
  input  logic [NumReq-1:0] vld,
  input  logic [IdW-1:0]    ptr,
  input  logic              locked,
  input  logic [IdW-1:0]    lock_id,
  output logic [NumReq-1:0] gnt,
  output logic [IdW-1:0]    win
);

  logic           found;
  logic [IdW-1:0] idx;
  int unsigned    sum;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= NumReq) begin
        sum = sum - NumReq;
      end
      idx = IdW'(sum);
      if (!found && vld[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win      = idx;
      end
    end
    if (locked && vld[lock_id]) begin
      gnt          = '0;
      gnt[lock_id] = 1'b1;
      win          = lock_id;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for the single-port RAM with a fixed-latency tag pipe that routes read data
// back to its requester. Define RAM_ARB_LOCK_EN to enable locked (atomic) bursts.
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  localparam int unsigned BlankW = $clog2(RamLatency + 1);

  logic [NumReq-1:0] gnt;
  logic [ReqIdW-1:0] win;
  logic [ReqIdW-1:0] ptr_q, ptr_d;
  logic [ReqIdW-1:0] lock_id;
  logic              locked;
  logic              xfer;
  ram_in_t           ram_q, ram_d;
  arb_tag_t          new_tag, last;
  arb_tag_pipe_t     tag_q, tag_d;
  logic [BlankW-1:0] blank_q, blank_d;
  logic              err_q, err_d;
  logic              blanking, hit;

  ram_arbiter_rr_grant #(
    .NumReq (NumReq),
    .IdW    (ReqIdW)
  ) u_grant (
    .vld     (bus.req_vld),
    .ptr     (ptr_q),
    .locked  (locked),
    .lock_id (lock_id),
    .gnt     (gnt),
    .win     (win)
  );

`ifdef RAM_ARB_LOCK_EN
  logic              locked_q;
  logic [ReqIdW-1:0] lock_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked_q  <= 1'b0;
      lock_id_q <= '0;
    end else begin
      locked_q <= xfer & bus.req_lock[win];
      if (xfer) begin
        lock_id_q <= win;
      end
    end
  end

  assign locked  = locked_q;
  assign lock_id = lock_id_q;
`else
  assign locked  = 1'b0;
  assign lock_id = '0;
`endif

  always_comb begin
    bus.req_rdy = rst_n ? gnt : '0;
    xfer        = |bus.req_rdy;
    ram_d       = '{en: xfer, wen: bus.req_wen[win], addr: bus.req_addr[win],
                    data: bus.req_data[win]};
    ptr_d       = xfer ? next_id(win) : ptr_q;
    new_tag     = '{rd_valid: xfer & ~bus.req_wen[win], req_id: win, addr: bus.req_addr[win]};
    tag_d       = {tag_q[RamLatency-1:0], new_tag};

    // Blanking swallows responses of reads that were in flight across a reset.
    blanking    = (blank_q != '0);
    blank_d     = blanking ? blank_q - 1'b1 : blank_q;
    last        = tag_q[RamLatency];
    hit         = bus.ram_rsp.dv & last.rd_valid & ~blanking;
    err_d       = err_q | (~blanking & (bus.ram_rsp.dv ^ last.rd_valid));
  end

  always_comb begin
    bus.rsp_vld = '0;
    bus.rsp_vld[last.req_id] = hit;
    bus.rsp_data = bus.ram_rsp.data;
    bus.rsp_addr = bus.ram_rsp.addr;
    bus.ram_req  = ram_q;
    bus.err      = err_q;
    bus.busy     = 1'b0;
    for (int unsigned i = 0; i <= RamLatency; i++) begin
      bus.busy = bus.busy | tag_q[i].rd_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_q   <= '0;
      ptr_q   <= '0;
      tag_q   <= '0;
      blank_q <= BlankW'(RamLatency);
      err_q   <= 1'b0;
    end else begin
      ram_q   <= ram_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      blank_q <= blank_d;
      err_q   <= err_d;
    end
  end

endmodule
